// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 3-sample majority voting, parity/framing/break/overrun detection,
// and a first-word-fall-through receive FIFO with a valid/ready drain port.
module uart_rx_ext #(
    parameter int unsigned CLK_FREQ   = 80_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx_in,
    input  logic                          i_data_ready,
    output logic [DATA_BITS-1:0]          o_data,
    output logic                          o_data_valid,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_break,
    output logic                          o_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_rx_busy,
    output logic [2:0]                    o_state_debug
);

    localparam int unsigned T  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned H  = T / 2;
    localparam int unsigned CW = $clog2(T) + 1;
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] C_HM2 = CW'(H - 2);
    localparam logic [CW-1:0] C_HM1 = CW'(H - 1);
    localparam logic [CW-1:0] C_H   = CW'(H);
    localparam logic [CW-1:0] C_TM1 = CW'(T - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic HAS_PAR  = (PARITY != 0);
    localparam logic ODD_PAR  = (PARITY == 2);
    localparam logic TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP1      = 3'd4,
        S_STOP2      = 3'd5,
        S_BREAK_WAIT = 3'd6
    } state_t;

    typedef struct packed {
        logic                 frame_err;
        logic                 parity_err;
        logic [DATA_BITS-1:0] data;
    } entry_t;

    state_t               state;
    logic                 rx_m, rx_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 s0, s1;
    logic                 par_bit;
    logic                 parity_err;
    logic                 frame_err;

    entry_t               mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [NW-1:0]        count;

    logic maj_c, par_x_c, fin_c, fe_c, brk_c, push_c, pop_c, full_c, do_push_c;

    // Two-flop synchroniser for the asynchronous line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx_in;
            rx_s <= rx_m;
        end
    end

    // Third vote is the live sample at counter H
    assign maj_c   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign par_x_c = (^shift) ^ maj_c;
    assign fin_c   = (cnt == C_H) &&
                     (((state == S_STOP1) && !TWO_STOP) || (state == S_STOP2));
    assign fe_c    = (state == S_STOP2) ? (frame_err | ~maj_c) : ~maj_c;
    assign brk_c   = fin_c && (shift == '0) && (!HAS_PAR || !par_bit) && fe_c;
    assign push_c  = fin_c && !brk_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            o_break    <= 1'b0;
        end else begin
            o_break <= 1'b0;
            if (cnt == C_HM2) s0 <= rx_s;
            if (cnt == C_HM1) s1 <= rx_s;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == C_HM1) begin
                        cnt        <= '0;
                        parity_err <= 1'b0;
                        frame_err  <= 1'b0;
                        state      <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == C_H) shift[bit_idx] <= maj_c;
                    if (cnt == C_TM1) begin
                        cnt <= '0;
                        if (bit_idx == LAST_BIT) state <= HAS_PAR ? S_PARITY : S_STOP1;
                        else                     bit_idx <= bit_idx + BW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt == C_H) begin
                        par_bit    <= maj_c;
                        parity_err <= ODD_PAR ? ~par_x_c : par_x_c;
                    end
                    if (cnt == C_TM1) begin
                        cnt   <= '0;
                        state <= S_STOP1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP1, S_STOP2: begin
                    if (cnt == C_H) frame_err <= fe_c;
                    if (fin_c) begin
                        // Leave mid-stop so the next start edge can be caught early
                        o_break <= brk_c;
                        state   <= brk_c ? S_BREAK_WAIT : S_IDLE;
                    end else if (cnt == C_TM1) begin
                        cnt   <= '0;
                        state <= S_STOP2;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BREAK_WAIT: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Receive FIFO: a push on full only lands when a pop frees a slot in the same cycle
    assign pop_c     = (count != '0) && i_data_ready;
    assign full_c    = (count == NW'(FIFO_DEPTH));
    assign do_push_c = push_c && (!full_c || pop_c);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= push_c && full_c && !pop_c;
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
            if (do_push_c && !pop_c)      count <= count + NW'(1);
            else if (!do_push_c && pop_c) count <= count - NW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push_c) mem[wr_ptr] <= {fe_c, parity_err, shift};
    end

    assign o_data_valid  = (count != '0);
    assign o_data        = o_data_valid ? mem[rd_ptr].data       : '0;
    assign o_parity_err  = o_data_valid ? mem[rd_ptr].parity_err : 1'b0;
    assign o_frame_err   = o_data_valid ? mem[rd_ptr].frame_err  : 1'b0;
    assign o_fifo_count  = count;
    assign o_rx_busy     = (state != S_IDLE);
    assign o_state_debug = state;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: four instances (8N1, 7E1, 7O1, 8N2) at T=16 cycles per bit.
module tb_uart_rx_ext;

    localparam int CLK = 1_600_000;
    localparam int BAUD = 100_000;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] rx  = 4'hF;
    logic [3:0] rdy = 4'h0;

    logic [7:0] d0, d3;
    logic [6:0] d1, d2;
    logic [3:0] v, pe, fe, brk, ovr, busy;
    logic [3:0][2:0] cnt, st;

    int n_cmp = 0;
    int n_bad = 0;
    int brk_cnt = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_ext #(.CLK_FREQ(CLK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .i_clk(clk), .i_rst(rst), .i_rx_in(rx[0]), .i_data_ready(rdy[0]), .o_data(d0),
        .o_data_valid(v[0]), .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_break(brk[0]),
        .o_overrun(ovr[0]), .o_fifo_count(cnt[0]), .o_rx_busy(busy[0]), .o_state_debug(st[0]));

    uart_rx_ext #(.CLK_FREQ(CLK), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .i_clk(clk), .i_rst(rst), .i_rx_in(rx[1]), .i_data_ready(rdy[1]), .o_data(d1),
        .o_data_valid(v[1]), .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_break(brk[1]),
        .o_overrun(ovr[1]), .o_fifo_count(cnt[1]), .o_rx_busy(busy[1]), .o_state_debug(st[1]));

    uart_rx_ext #(.CLK_FREQ(CLK), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .i_clk(clk), .i_rst(rst), .i_rx_in(rx[2]), .i_data_ready(rdy[2]), .o_data(d2),
        .o_data_valid(v[2]), .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_break(brk[2]),
        .o_overrun(ovr[2]), .o_fifo_count(cnt[2]), .o_rx_busy(busy[2]), .o_state_debug(st[2]));

    uart_rx_ext #(.CLK_FREQ(CLK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .i_clk(clk), .i_rst(rst), .i_rx_in(rx[3]), .i_data_ready(rdy[3]), .o_data(d3),
        .o_data_valid(v[3]), .o_parity_err(pe[3]), .o_frame_err(fe[3]), .o_break(brk[3]),
        .o_overrun(ovr[3]), .o_fifo_count(cnt[3]), .o_rx_busy(busy[3]), .o_state_debug(st[3]));

    // Pulse counters for the 8N1 instance
    always @(posedge clk) begin
        if (brk[0]) brk_cnt++;
        if (ovr[0]) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int ch, input logic val, input int cycles);
        rx[ch] = val;
        repeat (cycles) @(negedge clk);
    endtask

    // par < 0: no parity bit; glitch >= 0: first cycle of that data bit is forced low
    task automatic send(input int ch, input logic [8:0] d, input int nb, input int par,
                        input int nstop, input logic stop_v, input int glitch);
        drive(ch, 1'b0, T);
        for (int i = 0; i < nb; i++) begin
            if (i == glitch) begin
                drive(ch, 1'b0, 1);
                drive(ch, d[i], T - 1);
            end else begin
                drive(ch, d[i], T);
            end
        end
        if (par >= 0) drive(ch, par[0], T);
        for (int s = 0; s < nstop; s++) drive(ch, stop_v, T);
        rx[ch] = 1'b1;
    endtask

    task automatic pop(input int ch);
        rdy[ch] = 1'b1;
        @(negedge clk);
        rdy[ch] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, o0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(v[0]), 32'd0);
        chk("rst_data", 32'(d0), 32'd0);
        chk("rst_count", 32'(cnt[0]), 32'd0);
        chk("rst_state", 32'(st[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_errs", {30'd0, pe[0], fe[0]}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 basic frame, then single-cycle drain
        send(0, 9'h0A5, 8, -1, 1, 1'b1, -1);
        chk("a5_valid", 32'(v[0]), 32'd1);
        chk("a5_data", 32'(d0), 32'hA5);
        chk("a5_errs", {30'd0, pe[0], fe[0]}, 32'd0);
        chk("a5_count", 32'(cnt[0]), 32'd1);
        pop(0);
        chk("a5_drained_count", 32'(cnt[0]), 32'd0);
        chk("a5_drained_valid", 32'(v[0]), 32'd0);
        chk("a5_empty_data", 32'(d0), 32'd0);

        // 7-bit parity: 0x35 has four ones
        send(1, 9'h035, 7, 0, 1, 1'b1, -1);
        chk("even_p0_data", 32'(d1), 32'h35);
        chk("even_p0_perr", 32'(pe[1]), 32'd0);
        pop(1);
        send(1, 9'h035, 7, 1, 1, 1'b1, -1);
        chk("even_p1_data", 32'(d1), 32'h35);
        chk("even_p1_perr", 32'(pe[1]), 32'd1);
        pop(1);
        send(2, 9'h035, 7, 1, 1, 1'b1, -1);
        chk("odd_p1_data", 32'(d2), 32'h35);
        chk("odd_p1_perr", 32'(pe[2]), 32'd0);
        pop(2);

        // Short low pulse in IDLE is rejected at the mid-start check
        drive(0, 1'b0, 4);
        chk("glitch_busy", 32'(busy[0]), 32'd1);
        drive(0, 1'b1, 30);
        chk("glitch_state", 32'(st[0]), 32'd0);
        chk("glitch_count", 32'(cnt[0]), 32'd0);

        // One-cycle dip on data bit 3 is outvoted
        send(0, 9'h0FF, 8, -1, 1, 1'b1, 3);
        chk("dip_data", 32'(d0), 32'hFF);
        pop(0);

        // Stop bit low: entry carries frame error
        send(0, 9'h055, 8, -1, 1, 1'b0, -1);
        chk("ferr_data", 32'(d0), 32'h55);
        chk("ferr_flag", 32'(fe[0]), 32'd1);
        chk("ferr_perr", 32'(pe[0]), 32'd0);
        rdy[0] = 1'b1;
        repeat (12 * T) @(negedge clk);
        rdy[0] = 1'b0;
        chk("ferr_flushed", 32'(cnt[0]), 32'd0);
        chk("ferr_idle", 32'(st[0]), 32'd0);

        // Break: line low for 20 bit times
        b0 = brk_cnt;
        drive(0, 1'b0, 15 * T);
        chk("brk_state_mid", 32'(st[0]), 32'd6);
        chk("brk_pulses_mid", 32'(brk_cnt - b0), 32'd1);
        chk("brk_no_push", 32'(cnt[0]), 32'd0);
        drive(0, 1'b0, 5 * T);
        chk("brk_state_late", 32'(st[0]), 32'd6);
        drive(0, 1'b1, 6);
        chk("brk_release", 32'(st[0]), 32'd0);
        chk("brk_pulses", 32'(brk_cnt - b0), 32'd1);

        // Overrun: five back-to-back frames into a 4-deep FIFO
        o0 = ovr_cnt;
        for (int k = 1; k <= 5; k++) send(0, 9'(k), 8, -1, 1, 1'b1, -1);
        chk("ovr_count", 32'(cnt[0]), 32'd4);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            chk("ovr_drain", 32'(d0), 32'(k));
            pop(0);
        end
        chk("ovr_empty", 32'(cnt[0]), 32'd0);

        // Two stop bits, back-to-back
        send(3, 9'h012, 8, -1, 2, 1'b1, -1);
        send(3, 9'h034, 8, -1, 2, 1'b1, -1);
        chk("s2_count", 32'(cnt[3]), 32'd2);
        chk("s2_first", 32'(d3), 32'h12);
        chk("s2_ferr", 32'(fe[3]), 32'd0);
        pop(3);
        chk("s2_second", 32'(d3), 32'h34);
        pop(3);
        chk("s2_empty", 32'(cnt[3]), 32'd0);

        // Reset during DATA clears FIFO and frame
        send(0, 9'h05A, 8, -1, 1, 1'b1, -1);
        chk("mid_pre_count", 32'(cnt[0]), 32'd1);
        drive(0, 1'b0, T);
        drive(0, 1'b1, T);
        chk("mid_in_data", 32'(st[0]), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", 32'(st[0]), 32'd0);
        chk("mid_rst_count", 32'(cnt[0]), 32'd0);
        chk("mid_rst_valid", 32'(v[0]), 32'd0);
        rst = 1'b0;
        drive(0, 1'b1, 2 * T);
        send(0, 9'h03C, 8, -1, 1, 1'b1, -1);
        chk("mid_next_data", 32'(d0), 32'h3C);
        chk("mid_next_count", 32'(cnt[0]), 32'd1);
        chk("mid_next_ferr", 32'(fe[0]), 32'd0);
        pop(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
